dense_argmax: RTL and testbench



---
 rtl/dense_argmax.sv | 181 ++++++++++++++++++
 tb/tb_dense_argmax.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_argmax.sv
// dense_argmax: fully-connected classifier stage. Computes one dot product per
// class (bias + sum of feature*weight), one MAC per clock, with weights read
// from an external ROM that has one cycle of read latency. It reports every
// class score and the index of the highest score.
//
// state  | meaning
// IDLE   | waiting for start; results of the previous run stay visible
// BIAS   | load the accumulator with the bias of class o
// MAC    | strobe weight j of class o; accumulate feature j-1 with the weight returned for it
// DRAIN  | accumulate the last feature with the final ROM word
// STORE  | write score o, update argmax, advance to the next class
// FINISH | raise done, drop busy
module dense_argmax #(
    parameter int N_IN   = 5408,
    parameter int N_OUT  = 10,
    parameter int IN_W   = 8,
    parameter int W_W    = 4,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [N_IN*IN_W-1:0]     features,
    input  logic [N_OUT*W_W-1:0]     bias,
    output logic                     w_rd_en,
    output logic [ADDR_W-1:0]        w_addr,
    input  logic [W_W-1:0]           w_data,
    output logic [N_OUT*ACC_W-1:0]   scores,
    output logic [3:0]               class_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int JW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW = IN_W + W_W;

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_STORE, S_FINISH
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               o_q, o_d;
    logic [JW-1:0]            j_q, j_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  max_q, max_d;
    logic [N_OUT*ACC_W-1:0]   scores_q, scores_d;
    logic [3:0]               class_q, class_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;

    // The ROM word arriving now belongs to the feature strobed one cycle ago;
    // in DRAIN that is always the last feature.
    int                       feat_idx;
    logic signed [IN_W-1:0]   feat_sel;
    logic signed [W_W-1:0]    weight;
    logic signed [W_W-1:0]    bias_sel;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  bias_ext;
    logic [ADDR_W-1:0]        base_addr;

    // Datapath: feature select, signed product and accumulate, bias extension, row base address.
    always_comb begin
        feat_idx  = (state_q == S_MAC && j_q != '0) ? int'(j_q) - 1 : N_IN - 1;
        feat_sel  = features[feat_idx*IN_W +: IN_W];
        weight    = w_data;
        bias_sel  = bias[int'(o_q)*W_W +: W_W];
        prod      = feat_sel * weight;
        acc_sum   = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
        bias_ext  = {{(ACC_W-W_W){bias_sel[W_W-1]}}, bias_sel};
        base_addr = ADDR_W'(int'(o_q) * N_IN);
    end

    // Next-state and register-update logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        j_d      = j_q;
        acc_d    = acc_q;
        max_d    = max_q;
        scores_d = scores_q;
        class_d  = class_q;
        busy_d   = busy_q;
        done_d   = done_q;
        rd_en_d  = rd_en_q;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BIAS;
                    o_d     = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_BIAS: begin
                acc_d   = bias_ext;
                j_d     = '0;
                rd_en_d = 1'b1;
                addr_d  = base_addr;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (j_q != '0) begin
                    acc_d = acc_sum;
                end
                if (j_q == JW'(N_IN - 1)) begin
                    rd_en_d = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    j_d    = j_q + JW'(1);
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                acc_d   = acc_sum;
                state_d = S_STORE;
            end
            S_STORE: begin
                scores_d[int'(o_q)*ACC_W +: ACC_W] = acc_q;
                // Strict compare so a tie keeps the lower class index.
                if (o_q == '0 || acc_q > max_q) begin
                    max_d   = acc_q;
                    class_d = o_q;
                end
                if (o_q == 4'(N_OUT - 1)) begin
                    state_d = S_FINISH;
                end else begin
                    o_d     = o_q + 4'd1;
                    state_d = S_BIAS;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any partial result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            o_q      <= '0;
            j_q      <= '0;
            acc_q    <= '0;
            max_q    <= '0;
            scores_q <= '0;
            class_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            o_q      <= o_d;
            j_q      <= j_d;
            acc_q    <= acc_d;
            max_q    <= max_d;
            scores_q <= scores_d;
            class_q  <= class_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
        end
    end

    assign w_rd_en   = rd_en_q;
    assign w_addr    = addr_q;
    assign scores    = scores_q;
    assign class_idx = class_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_dense_argmax.sv
// Testbench for dense_argmax: a small instance (4 features, 3 classes) for the
// directed and random scenarios and a default-size instance for the mid-run
// reset and the full-size random inference. A plain-arithmetic model computes
// expected scores and argmax.
module tb_dense_argmax;

    localparam int NB = 5408;
    localparam int OB = 10;
    localparam int NS = 4;
    localparam int OS = 3;
    localparam int AW = 24;
    localparam int LIMIT = 60000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              start_s, start_b;
    logic [NS*8-1:0]   feat_s;
    logic [OS*4-1:0]   bias_s;
    logic [NB*8-1:0]   feat_b;
    logic [OB*4-1:0]   bias_b;
    logic              rd_s, rd_b;
    logic [15:0]       addr_s, addr_b;
    logic [3:0]        wd_s, wd_b;
    logic [OS*AW-1:0]  sc_s;
    logic [OB*AW-1:0]  sc_b;
    logic [3:0]        ci_s, ci_b;
    logic              busy_s, busy_b, done_s, done_b;

    logic signed [7:0] f_arr [0:NB-1];
    logic signed [3:0] w_arr [0:NB*OB-1];
    logic signed [3:0] b_arr [0:OB-1];
    int                exp_sc [0:OB-1];
    int                exp_ci;
    int                vectors = 0;
    int                miscompares = 0;
    int                addr_log [$];

    dense_argmax #(.N_IN(NS), .N_OUT(OS)) u_small (
        .clock(clk), .reset_n(reset_n), .start(start_s), .features(feat_s), .bias(bias_s),
        .w_rd_en(rd_s), .w_addr(addr_s), .w_data(wd_s), .scores(sc_s), .class_idx(ci_s),
        .busy(busy_s), .done(done_s));

    dense_argmax u_big (
        .clock(clk), .reset_n(reset_n), .start(start_b), .features(feat_b), .bias(bias_b),
        .w_rd_en(rd_b), .w_addr(addr_b), .w_data(wd_b), .scores(sc_b), .class_idx(ci_b),
        .busy(busy_b), .done(done_b));

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) if (rd_s) wd_s <= w_arr[addr_s];
    always @(posedge clk) if (rd_b) wd_b <= w_arr[addr_b];

    always @(negedge clk) if (rd_s) addr_log.push_back(int'(addr_s));

    task automatic pack();
        for (int i = 0; i < NS; i++) feat_s[i*8 +: 8] = f_arr[i];
        for (int i = 0; i < NB; i++) feat_b[i*8 +: 8] = f_arr[i];
        for (int o = 0; o < OS; o++) bias_s[o*4 +: 4] = b_arr[o];
        for (int o = 0; o < OB; o++) bias_b[o*4 +: 4] = b_arr[o];
    endtask

    task automatic randomize_data(input int n_in, input int n_out);
        for (int i = 0; i < n_in; i++) f_arr[i] = 8'($urandom);
        for (int k = 0; k < n_in*n_out; k++) w_arr[k] = 4'($urandom);
        for (int o = 0; o < n_out; o++) b_arr[o] = 4'($urandom);
        pack();
    endtask

    // Reference: score[o] = bias[o] + sum_i feature[i]*weight[o*n_in+i]; argmax with ties to lower index.
    task automatic model(input int n_in, input int n_out);
        for (int o = 0; o < n_out; o++) begin
            exp_sc[o] = int'(b_arr[o]);
            for (int i = 0; i < n_in; i++)
                exp_sc[o] += int'(f_arr[i]) * int'(w_arr[o*n_in + i]);
        end
        exp_ci = 0;
        for (int o = 1; o < n_out; o++)
            if (exp_sc[o] > exp_sc[exp_ci]) exp_ci = o;
    endtask

    task automatic set_start(input bit big, input logic v);
        if (big) start_b = v; else start_s = v;
    endtask

    // Pulse start, report busy/done right after the accept edge and the number
    // of edges until done reads 1; glitch >= 0 re-pulses start mid-run.
    task automatic run(input bit big, input int glitch, output int lat,
                       output logic busy0, output logic done0);
        @(negedge clk);
        set_start(big, 1'b1);
        @(posedge clk); #1;
        busy0 = big ? busy_b : busy_s;
        done0 = big ? done_b : done_s;
        set_start(big, 1'b0);
        lat = 0;
        do begin
            if (lat == glitch) set_start(big, 1'b1);
            @(posedge clk); #1;
            set_start(big, 1'b0);
            lat++;
        end while (!(big ? done_b : done_s) && lat < LIMIT);
    endtask

    task automatic test_reset();
        logic [31:0] got;
        reset_n = 1'b0; start_s = 1'b0; start_b = 1'b0;
        for (int i = 0; i < NB; i++) f_arr[i] = '0;
        for (int k = 0; k < NB*OB; k++) w_arr[k] = '0;
        for (int o = 0; o < OB; o++) b_arr[o] = '0;
        pack();
        #12;
        got = {busy_s, done_s, rd_s, ci_s};
        vectors++;
        if (got !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/done/rd_en/class = %h required 0", got);
        end
        vectors++;
        if (addr_s !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_addr: got %0d required 0", addr_s);
        end
        vectors++;
        if (sc_s !== '0) begin
            miscompares++;
            $display("FAIL reset_scores: got %h required 0", sc_s);
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_small_directed();
        int lat; logic b0, d0;
        int w1 [0:3] = '{-1, 0, 2, -8};
        logic [AW-1:0] e;
        for (int i = 0; i < NS; i++) begin
            f_arr[i] = 8'(i + 1);
            w_arr[i] = 4'sd1;
            w_arr[NS + i] = 4'(w1[i]);
            w_arr[2*NS + i] = 4'sd7;
        end
        b_arr[0] = 4'sd0; b_arr[1] = -4'sd8; b_arr[2] = -4'sd1;
        pack();
        model(NS, OS);
        addr_log.delete();
        run(0, -1, lat, b0, d0);
        vectors++;
        if (lat !== OS*(NS+3)+1) begin
            miscompares++;
            $display("FAIL directed_latency: got %0d required %0d", lat, OS*(NS+3)+1);
        end
        for (int o = 0; o < OS; o++) begin
            e = exp_sc[o][AW-1:0];
            vectors++;
            if (sc_s[o*AW +: AW] !== e) begin
                miscompares++;
                $display("FAIL directed_score%0d: got %0d required %0d", o, $signed(sc_s[o*AW +: AW]), exp_sc[o]);
            end
        end
        vectors++;
        if (ci_s !== 4'(exp_ci)) begin
            miscompares++;
            $display("FAIL directed_class: got %0d required %0d", ci_s, exp_ci);
        end
        vectors++;
        if (addr_log.size() !== NS*OS) begin
            miscompares++;
            $display("FAIL directed_strobes: got %0d required %0d", addr_log.size(), NS*OS);
        end else begin
            for (int k = 0; k < NS*OS; k++) begin
                vectors++;
                if (addr_log[k] !== k) begin
                    miscompares++;
                    $display("FAIL directed_addr%0d: got %0d required %0d", k, addr_log[k], k);
                end
            end
        end
        vectors++;
        if (rd_s !== 1'b0 || addr_s !== 16'(NS*OS-1)) begin
            miscompares++;
            $display("FAIL directed_addr_hold: rd_en %b addr %0d required 0 and %0d", rd_s, addr_s, NS*OS-1);
        end
    endtask

    task automatic test_tie_negative();
        int lat; logic b0, d0;
        logic [AW-1:0] e;
        for (int i = 0; i < NS; i++) f_arr[i] = 8'($urandom);
        for (int k = 0; k < NS*OS; k++) w_arr[k] = '0;
        b_arr[0] = -4'sd2; b_arr[1] = -4'sd2; b_arr[2] = -4'sd3;
        pack();
        model(NS, OS);
        run(0, -1, lat, b0, d0);
        for (int o = 0; o < OS; o++) begin
            e = exp_sc[o][AW-1:0];
            vectors++;
            if (sc_s[o*AW +: AW] !== e) begin
                miscompares++;
                $display("FAIL tie_score%0d: got %0d required %0d", o, $signed(sc_s[o*AW +: AW]), exp_sc[o]);
            end
        end
        vectors++;
        if (ci_s !== 4'(exp_ci)) begin
            miscompares++;
            $display("FAIL tie_class: got %0d required %0d", ci_s, exp_ci);
        end
    endtask

    task automatic test_extreme();
        int lat; logic b0, d0;
        logic [AW-1:0] e;
        for (int i = 0; i < NS; i++) f_arr[i] = 8'sd127;
        for (int k = 0; k < NS*OS; k++) w_arr[k] = -4'sd8;
        for (int o = 0; o < OS; o++) b_arr[o] = -4'sd8;
        pack();
        model(NS, OS);
        run(0, -1, lat, b0, d0);
        for (int o = 0; o < OS; o++) begin
            e = exp_sc[o][AW-1:0];
            vectors++;
            if (sc_s[o*AW +: AW] !== e) begin
                miscompares++;
                $display("FAIL extreme_score%0d: got %0d required %0d", o, $signed(sc_s[o*AW +: AW]), exp_sc[o]);
            end
        end
        vectors++;
        if (ci_s !== 4'd0) begin
            miscompares++;
            $display("FAIL extreme_class: got %0d required 0", ci_s);
        end
    endtask

    task automatic test_random_small();
        int lat; logic b0, d0;
        logic [AW-1:0] e;
        for (int t = 0; t < 8; t++) begin
            randomize_data(NS, OS);
            model(NS, OS);
            run(0, -1, lat, b0, d0);
            vectors++;
            if (lat !== OS*(NS+3)+1) begin
                miscompares++;
                $display("FAIL random_latency%0d: got %0d required %0d", t, lat, OS*(NS+3)+1);
            end
            for (int o = 0; o < OS; o++) begin
                e = exp_sc[o][AW-1:0];
                vectors++;
                if (sc_s[o*AW +: AW] !== e) begin
                    miscompares++;
                    $display("FAIL random%0d_score%0d: got %0d required %0d", t, o, $signed(sc_s[o*AW +: AW]), exp_sc[o]);
                end
            end
            vectors++;
            if (ci_s !== 4'(exp_ci)) begin
                miscompares++;
                $display("FAIL random%0d_class: got %0d required %0d", t, ci_s, exp_ci);
            end
        end
    endtask

    task automatic test_handshake();
        int lat; logic b0, d0;
        logic [AW-1:0] e;
        randomize_data(NS, OS);
        model(NS, OS);
        run(0, 5, lat, b0, d0);
        vectors++;
        if (lat !== OS*(NS+3)+1) begin
            miscompares++;
            $display("FAIL busy_start_latency: got %0d required %0d", lat, OS*(NS+3)+1);
        end
        vectors++;
        if (ci_s !== 4'(exp_ci) || sc_s[0 +: AW] !== exp_sc[0][AW-1:0]) begin
            miscompares++;
            $display("FAIL busy_start_result: class %0d score0 %0d required %0d %0d", ci_s, $signed(sc_s[0 +: AW]), exp_ci, exp_sc[0]);
        end
        // done is high now; start on this cycle must be accepted.
        randomize_data(NS, OS);
        model(NS, OS);
        run(0, -1, lat, b0, d0);
        vectors++;
        if (b0 !== 1'b1 || d0 !== 1'b0) begin
            miscompares++;
            $display("FAIL start_on_done_accept: busy %b done %b required 1 0", b0, d0);
        end
        vectors++;
        if (lat !== OS*(NS+3)+1) begin
            miscompares++;
            $display("FAIL start_on_done_latency: got %0d required %0d", lat, OS*(NS+3)+1);
        end
        for (int o = 0; o < OS; o++) begin
            e = exp_sc[o][AW-1:0];
            vectors++;
            if (sc_s[o*AW +: AW] !== e) begin
                miscompares++;
                $display("FAIL start_on_done_score%0d: got %0d required %0d", o, $signed(sc_s[o*AW +: AW]), exp_sc[o]);
            end
        end
        vectors++;
        if (ci_s !== 4'(exp_ci)) begin
            miscompares++;
            $display("FAIL start_on_done_class: got %0d required %0d", ci_s, exp_ci);
        end
    endtask

    task automatic test_reset_midrun_and_full();
        int lat; logic b0, d0;
        logic [AW-1:0] e;
        randomize_data(NB, OB);
        model(NB, OB);
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        repeat (3*(NB+3) + 20) @(posedge clk);
        #1;
        vectors++;
        if (busy_b !== 1'b1 || rd_b !== 1'b1 || addr_b < 16'(3*NB) || addr_b >= 16'(4*NB)) begin
            miscompares++;
            $display("FAIL midrun_class3: busy %b rd_en %b addr %0d required 1 1 within class 3", busy_b, rd_b, addr_b);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy_b, done_b, rd_b, ci_b} !== 7'd0 || addr_b !== 16'd0) begin
            miscompares++;
            $display("FAIL async_reset_ctrl: busy %b done %b rd_en %b class %0d addr %0d required all 0", busy_b, done_b, rd_b, ci_b, addr_b);
        end
        vectors++;
        if (sc_b !== '0 || sc_s !== '0 || ci_s !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset_results: scores not cleared (small class %0d) required 0", ci_s);
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: busy %b done %b required 0 0", busy_b, done_b);
        end
        run(1, -1, lat, b0, d0);
        vectors++;
        if (lat !== OB*(NB+3)+1) begin
            miscompares++;
            $display("FAIL full_latency: got %0d required %0d", lat, OB*(NB+3)+1);
        end
        for (int o = 0; o < OB; o++) begin
            e = exp_sc[o][AW-1:0];
            vectors++;
            if (sc_b[o*AW +: AW] !== e) begin
                miscompares++;
                $display("FAIL full_score%0d: got %0d required %0d", o, $signed(sc_b[o*AW +: AW]), exp_sc[o]);
            end
        end
        vectors++;
        if (ci_b !== 4'(exp_ci)) begin
            miscompares++;
            $display("FAIL full_class: got %0d required %0d", ci_b, exp_ci);
        end
    endtask

    initial begin
        test_reset();
        test_small_directed();
        test_tie_negative();
        test_extreme();
        test_random_small();
        test_handshake();
        test_reset_midrun_and_full();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
